// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between four bus masters and the round-robin bus arbiter.
// Pure wiring, no latency; the arbiter drives sel/gnt/busy/timeout, the masters drive req/done.
// Backpressure: a master waits on gnt; the arbiter never stalls a master that holds gnt.
interface bus_arbiter_rr_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  gnt,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output gnt,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin 4-master tri-state bus arbiter (IDLE/GRANT/TURN); ARB_TIMEOUT_EN adds a forced release.
// Latency: gnt appears one edge after req is sampled in IDLE; every grant is followed by one gnt=0 turn cycle.
// Backpressure: a grant is held until done or req[sel] drops (or, with ARB_TIMEOUT_EN, TIMEOUT_CYC cycles pass).
module bus_arbiter_rr #(
  parameter int TIMEOUT_CYC = 16
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_rr_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_TURN
  } state_t;

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;
  logic       busy_q;

  logic [1:0] win_idx;
  logic       win_vld;
  logic       release_req;
  logic       expire;

  // Search ptr+1, ptr+2, ptr+3, ptr; the 2-bit sum wraps 3->0 naturally.
  always_comb begin
    win_idx = ptr_q;
    win_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!win_vld && bus.req[2'(ptr_q + 2'(i))]) begin
        win_idx = 2'(ptr_q + 2'(i));
        win_vld = 1'b1;
      end
    end
  end

  assign release_req = bus.done || !bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_q;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign expire  = (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // Counter is parked at zero outside GRANT so it is clear on every GRANT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == ST_GRANT) && !release_req && expire;
      if (state_q == ST_GRANT) begin
        cnt_q <= cnt_inc;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b11;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q <= ST_GRANT;
            gnt_q   <= 4'b0001 << win_idx;
            sel_q   <= win_idx;
            ptr_q   <= win_idx;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (release_req || expire) begin
            state_q <= ST_TURN;
            gnt_q   <= 4'b0000;
          end
        end
        ST_TURN: begin
          // Turnaround: no driver enabled for one cycle, sel left on the last master.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr; observes {gnt, sel, busy, timeout} one delta after each rising edge.
module tb_bus_arbiter_rr;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  bus_arbiter_rr_if bus ();

  bus_arbiter_rr #(.TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {bus.gnt, bus.sel, bus.busy, bus.timeout};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    step(); step();
    exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL reset_state: got %b expected %b", obs, exp); end
    bus.req = 4'b1111;
    step();
    tests++; if (obs !== exp) begin failed++; $display("FAIL reset_over_req: got %b expected %b", obs, exp); end
    rst = 1'b0; bus.req = 4'b0000;
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    bus.req = 4'b0101;
    step(); exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL basic_grant0: got %b expected %b", obs, exp); end
    bus.done = 1'b1;
    step(); exp = {4'b0000, 2'd0, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL basic_turn: got %b expected %b", obs, exp); end
    bus.done = 1'b0;
    step(); exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL basic_idle: got %b expected %b", obs, exp); end
    step(); exp = {4'b0100, 2'd2, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL basic_grant2: got %b expected %b", obs, exp); end
    bus.req = 4'b0000;
    step(); exp = {4'b0000, 2'd2, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL basic_turn2: got %b expected %b", obs, exp); end
    step(); exp = {4'b0000, 2'd2, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL basic_idle2: got %b expected %b", obs, exp); end
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    logic [1:0] w;
    logic [3:0] g;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = 2'(k);
      g = 4'b0001 << w;
      step(); exp = {g, w, 1'b1, 1'b0};
      tests++; if (obs !== exp) begin failed++; $display("FAIL rot_grant%0d: got %b expected %b", k, obs, exp); end
      bus.done = 1'b1;
      step(); exp = {4'b0000, w, 1'b1, 1'b0};
      tests++; if (obs !== exp) begin failed++; $display("FAIL rot_turn%0d: got %b expected %b", k, obs, exp); end
      bus.done = 1'b0;
      step(); exp = {4'b0000, w, 1'b0, 1'b0};
      tests++; if (obs !== exp) begin failed++; $display("FAIL rot_idle%0d: got %b expected %b", k, obs, exp); end
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_req_drop();
    logic [7:0] exp;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b0110;
    step(); exp = {4'b0010, 2'd1, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL drop_grant1: got %b expected %b", obs, exp); end
    bus.req = 4'b0100;
    step(); exp = {4'b0000, 2'd1, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL drop_turn: got %b expected %b", obs, exp); end
    bus.done = 1'b1;
    step(); exp = {4'b0000, 2'd1, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL drop_done_in_turn: got %b expected %b", obs, exp); end
    step(); exp = {4'b0100, 2'd2, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL drop_done_in_idle: got %b expected %b", obs, exp); end
    bus.done = 1'b0; bus.req = 4'b0000;
    step(); exp = {4'b0000, 2'd2, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL drop_turn2: got %b expected %b", obs, exp); end
    step(); step(); exp = {4'b0000, 2'd2, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL drop_stay_idle: got %b expected %b", obs, exp); end
  endtask

  task automatic test_drop_in_turn();
    logic [7:0] exp;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b0011;
    step(); exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL dturn_grant0: got %b expected %b", obs, exp); end
    bus.done = 1'b1;
    step(); bus.done = 1'b0; bus.req = 4'b0000;
    step(); step(); exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL dturn_no_grant: got %b expected %b", obs, exp); end
  endtask

  task automatic test_simul_release();
    logic [7:0] exp;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b0001;
    step(); bus.done = 1'b1; bus.req = 4'b0000;
    step(); exp = {4'b0000, 2'd0, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL simul_turn: got %b expected %b", obs, exp); end
    bus.done = 1'b0;
    step(); exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL simul_idle: got %b expected %b", obs, exp); end
    bus.req = 4'b0001;
    step(); exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL simul_regrant: got %b expected %b", obs, exp); end
    bus.req = 4'b0000;
    step(); step();
  endtask

  task automatic test_rst_mid_grant();
    logic [7:0] exp;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b0100;
    step(); exp = {4'b0100, 2'd2, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL rstmid_grant2: got %b expected %b", obs, exp); end
    rst = 1'b1;
    step(); exp = {4'b0000, 2'd0, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL rstmid_drop: got %b expected %b", obs, exp); end
    rst = 1'b0; bus.req = 4'b1100;
    step(); exp = {4'b0100, 2'd2, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL rstmid_ptr: got %b expected %b", obs, exp); end
    bus.req = 4'b0000;
    step(); step();
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b1000;
    step(); exp = {4'b1000, 2'd3, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL tmo_grant3: got %b expected %b", obs, exp); end
`ifdef ARB_TIMEOUT_EN
    bus.req = 4'b1001;
    for (int i = 1; i < 4; i++) begin
      step();
      tests++; if (obs !== exp) begin failed++; $display("FAIL tmo_hold%0d: got %b expected %b", i, obs, exp); end
    end
    step(); exp = {4'b0000, 2'd3, 1'b1, 1'b1};
    tests++; if (obs !== exp) begin failed++; $display("FAIL tmo_fire: got %b expected %b", obs, exp); end
    step(); exp = {4'b0000, 2'd3, 1'b0, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL tmo_idle: got %b expected %b", obs, exp); end
    step(); exp = {4'b0001, 2'd0, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL tmo_next0: got %b expected %b", obs, exp); end
    bus.req = 4'b0000;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    bus.req = 4'b1000;
    step(); step(); step(); step();
    bus.done = 1'b1;
    step(); exp = {4'b0000, 2'd3, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL tmo_done_wins: got %b expected %b", obs, exp); end
    bus.done = 1'b0; bus.req = 4'b0000;
    step();
`else
    for (int i = 1; i <= 24; i++) begin
      step();
      tests++; if (obs !== exp) begin failed++; $display("FAIL notmo_hold%0d: got %b expected %b", i, obs, exp); end
    end
    bus.req = 4'b0000;
    step(); exp = {4'b0000, 2'd3, 1'b1, 1'b0};
    tests++; if (obs !== exp) begin failed++; $display("FAIL notmo_turn: got %b expected %b", obs, exp); end
    step();
`endif
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    test_reset();
    test_basic();
    test_rotation();
    test_req_drop();
    test_drop_in_turn();
    test_simul_release();
    test_rst_mid_grant();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, the number of grant cycles allowed without done before a forced release (used only when ARB_TIMEOUT_EN is defined).
REQ-002 Port: clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1 bit, synchronous, active-high reset.
REQ-004 Port: req, input, 4 bits, request from bus masters 0..3; level-sensitive.
REQ-005 Port: done, input, 1 bit, one-cycle pulse from the granted master ending its transfer.
REQ-006 Port: sel, output, 2 bits, index of the current or last granted master; drives the mux select of the downstream 4:1 tri-state bus mux.
REQ-007 Port: gnt, output, 4 bits, one-hot grant; gnt[i] enables the tri-state driver of master i.
REQ-008 Port: busy, output, 1 bit, high whenever the state is GRANT or TURN.
REQ-009 Port: timeout, output, 1 bit, one-cycle pulse on a forced release.

Function
REQ-010 The block shall implement a three-state FSM with states IDLE, GRANT and TURN, and all outputs shall be registered.
REQ-011 In IDLE with req==0: hold IDLE; gnt=0.
REQ-012 In IDLE with req!=0 at a rising edge, the same edge shall move to GRANT, set gnt to one-hot of the winner and set sel to the winner index, giving 1-cycle latency from req sampled to gnt visible.
REQ-013 The winner shall be the first requester with req bit set, searching ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last granted index.
REQ-014 ptr shall update to the winner index on each grant, and arithmetic on ptr shall be 2-bit, wrapping 3->0.
REQ-015 In GRANT, gnt and sel shall hold stable until release.
REQ-016 Release occurs when done==1 or req[sel]==0, and shall cause GRANT->TURN.
REQ-017 In TURN, gnt shall be 0 for exactly 1 cycle (bus turnaround, so no two tri-state drivers overlap), with sel unchanged, followed by TURN->IDLE.
REQ-018 gnt shall never have more than one bit set, and gnt shall be 0 in the cycle between any two different grants.
REQ-019 done while in IDLE or TURN shall be ignored.
REQ-020 A requester that drops req during TURN or IDLE shall not be granted.
REQ-021 Simultaneous done and req[sel] drop shall produce a single release, not a double TURN.
REQ-022 With a single persistent requester, the grant pattern shall repeat every 3 cycles: GRANT, TURN, IDLE.
REQ-023 busy shall be 1 in GRANT and TURN and 0 in IDLE.

Reset
REQ-024 While rst=1 at a rising edge: state=IDLE, gnt=4'b0000, sel=2'b00, ptr=2'b11 (so master 0 has first priority), busy=0, timeout=0, and the timeout counter=0.
REQ-025 rst shall take precedence over every other input, and reset mid-GRANT shall drop gnt to 0 on that same edge with no TURN cycle.
REQ-026 After rst deasserts, arbitration shall resume from IDLE on the next edge.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: a counter shall clear on entry to GRANT and increment each GRANT cycle, and if it reaches TIMEOUT_CYC without release, the FSM shall go GRANT->TURN with timeout=1 for that one TURN cycle.
REQ-028 Macro ARB_TIMEOUT_EN defined: done arriving in the same cycle as the count reaching TIMEOUT_CYC shall be treated as a normal release with timeout=0.
REQ-029 Macro ARB_TIMEOUT_EN undefined: no counter shall exist, timeout shall be tied to 0, and a grant shall be held indefinitely until done or a req drop.

Verification
REQ-030 Reset then req=4'b0101: gnt=0001, sel=0 one cycle later; after done: gnt=0000 for 1 cycle, then gnt=0100, sel=2.
REQ-031 req=4'b1111 held, done pulsed each grant: grant order 0,1,2,3,0 with gnt=0 between each; never two bits set.
REQ-032 Granted to master 1, deassert req[1] without done: TURN next cycle, then the next requester is granted; done in IDLE has no effect.
REQ-033 rst asserted during GRANT to master 2: gnt=0000, sel=0 on that edge; after release with req=4'b0100, master 2 is granted again (ptr reset to 3).
REQ-034 With ARB_TIMEOUT_EN and TIMEOUT_CYC=4, master 3 holds req with no done: gnt=1000 for 4 cycles, then timeout=1 with gnt=0000, then master 0 is granted if req[0]=1; without the macro, gnt=1000 persists beyond 20 cycles and timeout stays 0.
